// File: rtl/mips_control_unit.sv
// Main + ALU decoder for the single-cycle MIPS datapath.
// Ports: clk, rst, Opcode, Funct in; control strobes, ALUControl, IllegalInstr out.
module mips_control_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  output logic [2:0] ALUControl,
  output logic       MemtoReg,
  output logic       MemtoWrite,
  output logic       Branch,
  output logic       AluSrc,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       Jump,
  output logic       IllegalInstr
);

  logic [1:0] alu_op;
  logic       reg_write_main;
  logic       main_bad;
  logic       funct_bad;
  logic       illegal;

  always_comb begin
    reg_write_main = 1'b0;
    RegDst         = 1'b0;
    AluSrc         = 1'b0;
    Branch         = 1'b0;
    MemtoWrite     = 1'b0;
    MemtoReg       = 1'b0;
    Jump           = 1'b0;
    alu_op         = 2'b00;
    main_bad       = 1'b0;
    case (Opcode)
      6'b100011: begin
        reg_write_main = 1'b1;
        AluSrc         = 1'b1;
        MemtoReg       = 1'b1;
      end
      6'b101011: begin
        AluSrc     = 1'b1;
        MemtoWrite = 1'b1;
      end
      6'b000000: begin
        reg_write_main = 1'b1;
        RegDst         = 1'b1;
        alu_op         = 2'b10;
      end
      6'b000100: begin
        Branch = 1'b1;
        alu_op = 2'b01;
      end
      6'b001000: begin
        reg_write_main = 1'b1;
        AluSrc         = 1'b1;
      end
      6'b000010: Jump = 1'b1;
      // Unknown or X/Z opcodes fall here, so strobes stay 0.
      default: main_bad = 1'b1;
    endcase
  end

  always_comb begin
    ALUControl = 3'b010;
    funct_bad  = 1'b0;
    case (alu_op)
      2'b00: ALUControl = 3'b010;
      2'b01: ALUControl = 3'b100;
      2'b10: begin
        case (Funct)
          6'b100000: ALUControl = 3'b010;
          6'b100010: ALUControl = 3'b100;
          6'b101010: ALUControl = 3'b110;
          6'b011100: ALUControl = 3'b101;
          6'b100100: ALUControl = 3'b000;
          6'b100101: ALUControl = 3'b001;
          default: begin
            ALUControl = 3'b010;
            funct_bad  = 1'b1;
          end
        endcase
      end
      default: ALUControl = 3'b010;
    endcase
  end

  // A bad R-type funct must not commit a register write.
  assign RegWrite = reg_write_main & ~funct_bad;
  assign illegal  = main_bad | funct_bad;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      IllegalInstr <= 1'b0;
    else if (illegal)
      IllegalInstr <= 1'b1;
  end

endmodule

// File: tb/tb_mips_control_unit.sv
// Self-checking bench for mips_control_unit.
// Directed steps, then random opcodes/functs against a table-based model.
module tb_mips_control_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] Opcode;
  logic [5:0] Funct;
  logic [2:0] ALUControl;
  logic       MemtoReg;
  logic       MemtoWrite;
  logic       Branch;
  logic       AluSrc;
  logic       RegDst;
  logic       RegWrite;
  logic       Jump;
  logic       IllegalInstr;

  int errors = 0;
  int checks = 0;
  bit model_flag = 1'b0;

  always #5 clk = ~clk;

  mips_control_unit dut (
    .clk          (clk),
    .rst          (rst),
    .Opcode       (Opcode),
    .Funct        (Funct),
    .ALUControl   (ALUControl),
    .MemtoReg     (MemtoReg),
    .MemtoWrite   (MemtoWrite),
    .Branch       (Branch),
    .AluSrc       (AluSrc),
    .RegDst       (RegDst),
    .RegWrite     (RegWrite),
    .Jump         (Jump),
    .IllegalInstr (IllegalInstr)
  );

  // Expected vector: {ALUControl, RegWrite, RegDst, AluSrc, Branch,
  // MemtoWrite, MemtoReg, Jump}. Strobe strings are taken straight
  // from the instruction table in the order listed there.
  function automatic void model(input logic [5:0] op,
                                input logic [5:0] fn,
                                output logic [9:0] exp,
                                output bit bad);
    logic [6:0] s;
    logic [2:0] alu;
    bad = 1'b0;
    alu = 3'b010;
    case (op)
      6'b100011: s = 7'b1010010;
      6'b101011: s = 7'b0010100;
      6'b000100: begin s = 7'b0001000; alu = 3'b100; end
      6'b001000: s = 7'b1010000;
      6'b000010: s = 7'b0000001;
      6'b000000: begin
        s = 7'b1100000;
        case (fn)
          6'b100000: alu = 3'b010;
          6'b100010: alu = 3'b100;
          6'b101010: alu = 3'b110;
          6'b011100: alu = 3'b101;
          6'b100100: alu = 3'b000;
          6'b100101: alu = 3'b001;
          default: begin
            s[6] = 1'b0;
            bad  = 1'b1;
          end
        endcase
      end
      default: begin s = 7'b0; bad = 1'b1; end
    endcase
    exp = {alu, s};
  endfunction

  function automatic logic [9:0] observed();
    return {ALUControl, RegWrite, RegDst, AluSrc, Branch,
            MemtoWrite, MemtoReg, Jump};
  endfunction

  task automatic check_flag(input string tag);
    checks++;
    assert (IllegalInstr === model_flag) else begin
      errors++;
      $error("FAIL %s flag: observed=%b expected=%b",
             tag, IllegalInstr, model_flag);
    end
  endtask

  task automatic apply(input logic [5:0] op, input logic [5:0] fn,
                       input string tag);
    logic [9:0] exp;
    bit bad;
    Opcode = op;
    Funct  = fn;
    #1;
    model(op, fn, exp, bad);
    checks++;
    assert (observed() === exp) else begin
      errors++;
      $error("FAIL %s ctl op=%b fn=%b: observed=%b expected=%b",
             tag, op, fn, observed(), exp);
    end
  endtask

  task automatic tick(input string tag);
    logic [9:0] exp;
    bit bad;
    model(Opcode, Funct, exp, bad);
    @(posedge clk);
    if (rst) model_flag = 1'b0;
    else if (bad) model_flag = 1'b1;
    #1;
    check_flag(tag);
  endtask

  logic [5:0] ops [6] = '{6'b100011, 6'b101011, 6'b000000,
                          6'b000100, 6'b001000, 6'b000010};
  logic [5:0] fns [6] = '{6'b100000, 6'b100010, 6'b101010,
                          6'b011100, 6'b100100, 6'b100101};

  initial begin
    rst    = 1'b1;
    Opcode = 6'b100011;
    Funct  = 6'b0;
    #2;
    check_flag("reset");
    tick("reset_edge");
    rst = 1'b0;

    apply(6'b100011, 6'b000000, "lw");
    tick("lw");
    apply(6'b101011, 6'b111111, "sw");
    apply(6'b000000, 6'b100000, "r_add");
    apply(6'b000000, 6'b011100, "r_mul");
    apply(6'b000000, 6'b100010, "r_sub");
    apply(6'b000000, 6'b101010, "r_slt");
    apply(6'b000000, 6'b100100, "r_and");
    apply(6'b000000, 6'b100101, "r_or");
    apply(6'b000100, 6'b000000, "beq");
    apply(6'b001000, 6'b000000, "addi");
    apply(6'b000010, 6'b000000, "j");
    tick("legal_edge");

    apply(6'b111111, 6'b000000, "ill_op");
    tick("ill_set");
    apply(6'b100011, 6'b000000, "lw_after");
    tick("sticky");
    rst = 1'b1;
    #1;
    model_flag = 1'b0;
    check_flag("async_clr");
    apply(6'b000000, 6'b000001, "bad_funct");
    tick("rst_wins");
    rst = 1'b0;
    tick("bad_funct_set");

    for (int i = 0; i < 300; i++) begin
      logic [5:0] op, fn;
      op = ($urandom_range(0, 3) == 0) ? 6'($urandom)
                                       : ops[$urandom_range(0, 5)];
      fn = ($urandom_range(0, 3) == 0) ? 6'($urandom)
                                       : fns[$urandom_range(0, 5)];
      if ($urandom_range(0, 19) == 0) begin
        rst = 1'b1;
        #1;
        model_flag = 1'b0;
        check_flag("rnd_rst");
      end
      apply(op, fn, "rnd");
      tick("rnd_edge");
      rst = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
